// File: rtl/alu_issue_pkg.sv
// Shared definitions for the TotalALU command issue queue: funct codes, command and tag
// layouts, FSM states. The MFHI/MFLO states exist only when AUTO_MFHILO_EN is defined.
package alu_issue_pkg;

  localparam logic [5:0] FUNCT_AND  = 6'd36;
  localparam logic [5:0] FUNCT_OR   = 6'd37;
  localparam logic [5:0] FUNCT_ADD  = 6'd32;
  localparam logic [5:0] FUNCT_SUB  = 6'd34;
  localparam logic [5:0] FUNCT_SLT  = 6'd42;
  localparam logic [5:0] FUNCT_SRL  = 6'd2;
  localparam logic [5:0] FUNCT_DIVU = 6'd27;
  localparam logic [5:0] FUNCT_MFHI = 6'd16;
  localparam logic [5:0] FUNCT_MFLO = 6'd18;

  localparam int unsigned CMD_W = 70;

  typedef enum logic [2:0] {
    StIdle,
    StDivHold,
`ifdef AUTO_MFHILO_EN
    StDivSettle,
    StMfhi,
    StMflo
`else
    StDivSettle
`endif
  } state_e;

  typedef struct packed {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  typedef struct packed {
    logic       valid;
    logic [5:0] funct;
  } tag_t;

  function automatic logic is_supported(input logic [5:0] funct);
    return funct inside {FUNCT_AND, FUNCT_OR, FUNCT_ADD, FUNCT_SUB, FUNCT_SLT, FUNCT_SRL,
                         FUNCT_DIVU, FUNCT_MFHI, FUNCT_MFLO};
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with wrapping pointers and an occupancy count.
// Push is ignored when full and pop when empty, so callers may drive them loosely.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 70,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             empty
);

  localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_push = push && (count_q != DepthCnt);
  assign do_pop  = pop && (count_q != '0);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/alu_issue_queue.sv
// Command issue stage in front of TotalALU: buffers commands, holds DIVU operands for the
// divider, and turns registered ALU output into tagged result pulses. AUTO_MFHILO_EN adds MFHI/MFLO.
module alu_issue_queue
  import alu_issue_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter logic [5:0]  IDLE_FUNCT = 6'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_funct,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [5:0]  alu_signal,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  output logic        res_valid,
  output logic [5:0]  res_funct,
  output logic [31:0] res_data,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [AW:0] DepthCnt   = (AW + 1)'(DEPTH);
  localparam int unsigned CntW       = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CntW-1:0] DivLast    = CntW'(DIV_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(1);

  cmd_t        wr_cmd, head;
  logic [AW:0] fifo_count;
  logic        fifo_empty;
  logic        push, pop, issue_slot, is_div;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      signal_q, signal_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  tag_t            tag0_q, tag1_q, tag_d;
  logic            err_q, err_d;
  logic            res_valid_q;
  logic [5:0]      res_funct_q;
  logic [31:0]     res_data_q;

  // A pop never frees space for a push in the same cycle: readiness looks only at count.
  assign in_ready = !reset && (fifo_count != DepthCnt);
  assign push     = in_valid && in_ready;
  assign wr_cmd   = '{funct: in_funct, a: in_a, b: in_b};

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wr_cmd),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign is_div = (head.funct == FUNCT_DIVU);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    issue_slot = 1'b0;
    case (state_q)
      StIdle: issue_slot = 1'b1;
      StDivHold: begin
        if (cnt_q == DivLast) begin
          state_d = StDivSettle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDivSettle: begin
        if (cnt_q == SettleLast) begin
          cnt_d = '0;
`ifdef AUTO_MFHILO_EN
          state_d = StMfhi;
`else
          // Last settle cycle doubles as an issue slot so the next command follows directly.
          state_d    = StIdle;
          issue_slot = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef AUTO_MFHILO_EN
      StMfhi: state_d = StMflo;
      StMflo: begin
        state_d    = StIdle;
        issue_slot = 1'b1;
      end
`endif
      default: state_d = StIdle;
    endcase

    pop = issue_slot && !fifo_empty;
    if (pop && is_div) begin
      state_d = StDivHold;
      cnt_d   = '0;
    end

    signal_d = IDLE_FUNCT;
    a_d      = a_q;
    b_d      = b_q;
    tag_d    = '0;
    err_d    = 1'b0;
    if (state_d == StDivHold) begin
      signal_d = FUNCT_DIVU;
    end
`ifdef AUTO_MFHILO_EN
    if (state_d == StMfhi) begin
      signal_d    = FUNCT_MFHI;
      tag_d.valid = 1'b1;
      tag_d.funct = FUNCT_MFHI;
    end else if (state_d == StMflo) begin
      signal_d    = FUNCT_MFLO;
      tag_d.valid = 1'b1;
      tag_d.funct = FUNCT_MFLO;
    end
`endif
    if (pop) begin
      if (is_div) begin
        a_d = head.a;
        b_d = head.b;
      end else if (is_supported(head.funct)) begin
        signal_d    = head.funct;
        a_d         = head.a;
        b_d         = head.b;
        tag_d.valid = 1'b1;
        tag_d.funct = head.funct;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      signal_q    <= IDLE_FUNCT;
      a_q         <= '0;
      b_q         <= '0;
      tag0_q      <= '0;
      tag1_q      <= '0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_funct_q <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      signal_q    <= signal_d;
      a_q         <= a_d;
      b_q         <= b_d;
      // tag0 matches the command on alu_*, tag1 the value TotalALU has just registered.
      tag0_q      <= tag_d;
      tag1_q      <= tag0_q;
      err_q       <= err_d;
      res_valid_q <= tag1_q.valid;
      if (tag1_q.valid) begin
        res_funct_q <= tag1_q.funct;
        res_data_q  <= alu_out;
      end
    end
  end

  assign alu_signal = signal_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign res_valid  = res_valid_q;
  assign res_funct  = res_funct_q;
  assign res_data   = res_data_q;
  assign err        = err_q;
  assign busy       = !fifo_empty || (state_q != StIdle) || tag0_q.valid || tag1_q.valid ||
                      res_valid_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: 1-cycle TotalALU stand-in with a DIVU hold model, directed
// scenarios plus random traffic checked against an in-order expected-result queue.
module tb_alu_issue_queue;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned DIV_CYCLES = 32;
`ifdef AUTO_MFHILO_EN
  localparam int T3Add = 36;
`else
  localparam int T3Add = 34;
`endif

  typedef struct {
    logic [5:0]  f;
    logic [31:0] d;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [5:0]  in_funct = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_ready, res_valid, err, busy;
  logic [5:0]  alu_signal, res_funct;
  logic [31:0] alu_a, alu_b, res_data;
  logic [31:0] alu_out_m = '0;
  logic [31:0] hi_m = '0, lo_m = '0;
  int          div_cnt = 0;

  res_t        exp_q[$];
  logic [31:0] ref_hi = '0, ref_lo = '0;
  int          err_exp = 0, err_seen = 0;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  alu_issue_queue dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct   (in_funct),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_signal (alu_signal),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out_m),
    .res_valid  (res_valid),
    .res_funct  (res_funct),
    .res_data   (res_data),
    .err        (err),
    .busy       (busy)
  );

  function automatic logic [31:0] alu_fn(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    case (f)
      6'd36:   return a & b;
      6'd37:   return a | b;
      6'd32:   return a + b;
      6'd34:   return a - b;
      6'd42:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd2:    return a >> b[4:0];
      6'd16:   return hi;
      6'd18:   return lo;
      default: return 32'd0;
    endcase
  endfunction

  // TotalALU stand-in: Output registered one edge later; Hi/Lo only after a full DIVU hold.
  always @(posedge clk) begin
    alu_out_m <= alu_fn(alu_signal, alu_a, alu_b, hi_m, lo_m);
    if (alu_signal == 6'd27) begin
      div_cnt <= div_cnt + 1;
      if (div_cnt == DIV_CYCLES - 1 && alu_b != 0) begin
        hi_m <= alu_a % alu_b;
        lo_m <= alu_a / alu_b;
      end
    end else begin
      div_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic supported(input logic [5:0] f);
    return f inside {6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd16, 6'd18};
  endfunction

  task automatic model_push(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    if (f == 6'd27) begin
      ref_hi = a % b;
      ref_lo = a / b;
`ifdef AUTO_MFHILO_EN
      r.f = 6'd16; r.d = ref_hi; exp_q.push_back(r);
      r.f = 6'd18; r.d = ref_lo; exp_q.push_back(r);
`endif
    end else if (supported(f)) begin
      r.f = f;
      r.d = alu_fn(f, a, b, ref_hi, ref_lo);
      exp_q.push_back(r);
    end else begin
      err_exp++;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_cmd(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_funct = f;
    in_a     = a;
    in_b     = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_ready", 32'(in_ready), 32'd1);
    else model_push(f, a, b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : monitor
    res_t r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (err) err_seen++;
        if (res_valid) begin
          if (exp_q.size() == 0) begin
            check("res_spurious", 32'(res_valid), 32'd0);
          end else begin
            r = exp_q.pop_front();
            check("res_funct", 32'(res_funct), 32'(r.f));
            check("res_data", res_data, r.d);
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [5:0]  ops [8] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd16, 6'd18};
    logic [5:0]  f;
    logic [31:0] a, b;
    int          hold, t_add, n, r, busy_cycles, sig_cycles;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_alu_signal", 32'(alu_signal), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // 1: single ADD latency
    push_cmd(6'd32, 32'd5, 32'd7);
    @(negedge clk);
    check("t1_signal", 32'(alu_signal), 32'd32);
    check("t1_alu_a", alu_a, 32'd5);
    check("t1_alu_b", alu_b, 32'd7);
    @(negedge clk);
    check("t1_res_early", 32'(res_valid), 32'd0);
    @(negedge clk);
    check("t1_res_valid", 32'(res_valid), 32'd1);
    check("t1_res_data", res_data, 32'd12);
    check("t1_res_funct", 32'(res_funct), 32'd32);
    wait_idle();

    // 2: back-to-back throughput
    push_cmd(6'd36, 32'd12, 32'd10);
    push_cmd(6'd37, 32'd12, 32'd10);
    push_cmd(6'd34, 32'd9, 32'd4);
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t2_v0", 32'(res_valid), 32'd1);
    check("t2_d0", res_data, 32'd8);
    @(negedge clk);
    check("t2_v1", 32'(res_valid), 32'd1);
    check("t2_d1", res_data, 32'd14);
    @(negedge clk);
    check("t2_v2", 32'(res_valid), 32'd1);
    check("t2_d2", res_data, 32'd5);
    wait_idle();

    // 3: DIVU hold length and issue gap
    push_cmd(6'd27, 32'd100, 32'd7);
    push_cmd(6'd32, 32'd1, 32'd1);
    hold  = 0;
    t_add = -1;
    for (int t = 0; t < 60; t++) begin
      if (alu_signal == 6'd27) hold++;
      if (alu_signal == 6'd32 && t_add < 0) t_add = t;
      @(negedge clk);
    end
    check("t3_hold", 32'(hold), 32'(DIV_CYCLES));
    check("t3_add_lat", 32'(t_add), 32'(T3Add));
    wait_idle();

    // 4: fill the FIFO while the divider holds issue
    push_cmd(6'd27, 32'd1000, 32'd3);
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_cmd(6'd32, 32'(i), 32'd100);
    check("t4_full", 32'(in_ready), 32'd0);
    check("t4_hold", 32'(alu_signal), 32'd27);
    push_cmd(6'd32, 32'd4, 32'd100);
    wait_idle();
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // 5: unsupported funct dropped with err
    push_cmd(6'd63, 32'd0, 32'd0);
    push_cmd(6'd32, 32'd2, 32'd3);
    check("t5_err", 32'(err), 32'd1);
    check("t5_no_drive", 32'(alu_signal), 32'd0);
    wait_idle();

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r = $urandom_range(0, 17);
      if (r < 16) f = ops[r % 8];
      else if (r == 16) f = 6'd27;
      else f = ($urandom_range(0, 1) != 0) ? 6'd63 : 6'd1;
      a = $urandom;
      b = (f == 6'd27) ? 32'($urandom_range(1, 5000)) : $urandom;
      push_cmd(f, a, b);
    end
    wait_idle();
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    // 6: reset in the middle of a DIVU hold
    push_cmd(6'd27, 32'd50, 32'd5);
    @(negedge clk);
    push_cmd(6'd32, 32'd1, 32'd2);
    push_cmd(6'd32, 32'd3, 32'd4);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("t6_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("t6_signal", 32'(alu_signal), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_res_valid", 32'(res_valid), 32'd0);
    reset = 1'b0;
    busy_cycles = 0;
    sig_cycles  = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (alu_signal != 6'd0) sig_cycles++;
    end
    check("t6_stay_idle", 32'(busy_cycles), 32'd0);
    check("t6_no_issue", 32'(sig_cycles), 32'd0);

    check("err_count", 32'(err_seen), 32'(err_exp));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
